// File: rtl/leg_fetch.sv
// leg_fetch: byte-serial LEG instruction fetch with redirect and valid/ready output
// Ports: clk/rst; mem_rd/mem_addr/mem_rdata to 1-cycle-latency program memory;
// redirect/redirect_pc from the jump unit; out_valid/out_ready handshake with
// out_opcode/out_arg1/out_arg2/out_dest/out_pc towards decode.
module leg_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_opcode,
  output logic [7:0]            out_arg1,
  output logic [7:0]            out_arg2,
  output logic [7:0]            out_dest,
  output logic [ADDR_WIDTH-1:0] out_pc
);
  typedef enum logic [1:0] {ISSUE, DRAIN, VALID} state_t;
  state_t state, state_n;
  logic [1:0] cnt, cnt_n, slot;
  logic [ADDR_WIDTH-1:0] fetch_pc, pc_n;
  logic [3:0][7:0] payload;
  logic pend;
  assign out_valid = state == VALID;
  assign mem_rd = state == ISSUE && !redirect && !rst;
  assign mem_addr = fetch_pc + ADDR_WIDTH'(cnt);
  assign out_pc = fetch_pc;
  // payload is only exposed once complete, so partial or stale bytes never leak
  assign out_opcode = out_valid ? payload[0] : '0;
  assign out_arg1 = out_valid ? payload[1] : '0;
  assign out_arg2 = out_valid ? payload[2] : '0;
  assign out_dest = out_valid ? payload[3] : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_n = fetch_pc;
    if (redirect) begin
      state_n = ISSUE;
      cnt_n = '0;
      pc_n = redirect_pc;
    end else if (state == ISSUE) begin
      cnt_n = cnt + 2'd1;
      state_n = cnt == 2'd3 ? DRAIN : ISSUE;
    end else if (state == DRAIN) begin
      state_n = VALID;
    end else if (out_ready) begin
      state_n = ISSUE;
      cnt_n = '0;
      pc_n = fetch_pc + ADDR_WIDTH'(4);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ISSUE;
      cnt <= '0;
      fetch_pc <= RESET_PC;
      pend <= 1'b0;
      slot <= '0;
      payload <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fetch_pc <= pc_n;
      pend <= mem_rd;
      slot <= cnt;
      // a byte arriving in a redirect cycle belongs to the abandoned fetch
      if (pend && !redirect) payload[slot] <= mem_rdata;
    end
  end
endmodule
